// File: rtl/pc_fetch.sv
// Instruction fetch sequencer: one outstanding imem request, a single-entry hold slot and redirect handling.
// Optional build macro PC_FETCH_MISALIGN_CHECK_EN rejects misaligned redirects and pulses misalign_err.
module pc_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        redirect_en,
  input  logic [63:0] redirect_addr,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_r;
  logic [63:0] fetch_pc_r;
  logic        drop_r;
  logic [31:0] inst_r;
  logic [63:0] inst_pc_r;
  logic        req_valid_r;
  logic [63:0] req_addr_r;
  logic        inst_valid_r;
  logic        misalign_r;

  state_t      state_nxt_s;
  logic [63:0] fetch_pc_nxt_s;
  logic        drop_nxt_s;
  logic        load_inst_s;
  logic        redir_s;
  logic        misalign_s;
  logic [63:0] redir_pc_s;

  // Next-state, next-pc and drop decisions for the fetch sequencer.
  always_comb begin
    redir_pc_s = redirect_addr & ~64'd3;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    misalign_s = redirect_en && (state_r != S_BOOT) && (redirect_addr[1:0] != 2'b00);
`else
    misalign_s = 1'b0;
`endif
    redir_s        = redirect_en && (state_r != S_BOOT) && !misalign_s;
    state_nxt_s    = state_r;
    fetch_pc_nxt_s = fetch_pc_r;
    drop_nxt_s     = drop_r;
    load_inst_s    = 1'b0;
    case (state_r)
      S_BOOT: begin
        state_nxt_s    = S_REQ;
        fetch_pc_nxt_s = RESET_PC;
        drop_nxt_s     = 1'b0;
      end
      S_REQ: begin
        if (redir_s) begin
          fetch_pc_nxt_s = redir_pc_s;
        end else begin
          fetch_pc_nxt_s = fetch_pc_r;
        end
        // An accepted request overtaken by a redirect returns a stale word.
        if (imem_req_ready) begin
          state_nxt_s = S_WAIT;
          drop_nxt_s  = redir_s;
        end else begin
          state_nxt_s = S_REQ;
          drop_nxt_s  = drop_r;
        end
      end
      S_WAIT: begin
        if (redir_s) begin
          fetch_pc_nxt_s = redir_pc_s;
          // A response in the redirect cycle retires the outstanding request.
          if (imem_rsp_valid) begin
            state_nxt_s = S_REQ;
            drop_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = S_WAIT;
            drop_nxt_s  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          drop_nxt_s = 1'b0;
          if (drop_r) begin
            state_nxt_s = S_REQ;
          end else begin
            state_nxt_s = S_HOLD;
            load_inst_s = 1'b1;
          end
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redir_s) begin
          fetch_pc_nxt_s = redir_pc_s;
          state_nxt_s    = S_REQ;
        end else if (inst_ready) begin
          fetch_pc_nxt_s = fetch_pc_r + 64'd4;
          state_nxt_s    = S_REQ;
        end else begin
          state_nxt_s = S_HOLD;
        end
      end
      default: begin
        state_nxt_s    = S_BOOT;
        fetch_pc_nxt_s = RESET_PC;
        drop_nxt_s     = 1'b0;
      end
    endcase
  end

  // State, pc and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_BOOT;
      fetch_pc_r   <= RESET_PC;
      drop_r       <= 1'b0;
      inst_r       <= 32'd0;
      inst_pc_r    <= 64'd0;
      req_valid_r  <= 1'b0;
      req_addr_r   <= 64'd0;
      inst_valid_r <= 1'b0;
      misalign_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      fetch_pc_r   <= fetch_pc_nxt_s;
      drop_r       <= drop_nxt_s;
      req_valid_r  <= (state_nxt_s == S_REQ);
      req_addr_r   <= fetch_pc_nxt_s;
      inst_valid_r <= (state_nxt_s == S_HOLD);
      misalign_r   <= misalign_s;
      if (load_inst_s) begin
        inst_r    <= imem_rsp_data;
        inst_pc_r <= fetch_pc_r + 64'd4;
      end else begin
        inst_r    <= inst_r;
        inst_pc_r <= inst_pc_r;
      end
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = req_addr_r;
  assign inst_valid     = inst_valid_r;
  assign inst           = inst_r;
  assign inst_pc        = inst_pc_r;
  assign misalign_err   = misalign_r;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus randomized traffic against a scoreboard of the expected
// architectural instruction stream (address -> word via a fixed memory function).
module tb_pc_fetch;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_en;
  logic [63:0] redirect_addr;
  logic        misalign_err;

  pc_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr), .misalign_err(misalign_err)
  );

  typedef struct {
    logic [63:0] pc4;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          rdy_mode = 1;   // 0 never ready, 1 always ready, 2 random
  int          lat_max = 0;
  bit          spurious = 0;
  logic [63:0] pend_pc = RESET_PC;
  bit          in_boot = 1'b1;
  bit          mis_exp = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hA5C3_0F13;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: next instruction address the program should see, advanced per negedge.
  task automatic model_upd();
    bit misaligned;
    chk("misalign_err", {63'd0, misalign_err}, {63'd0, mis_exp});
    mis_exp = 1'b0;
    if (rst) begin
      exp_q.delete();
      pend_pc = RESET_PC;
      in_boot = 1'b1;
    end else begin
      if (inst_valid === 1'b1 && inst_ready) begin
        exp_q.push_back('{pc4: pend_pc + 64'd4, word: mem_word(pend_pc)});
        pend_pc = pend_pc + 64'd4;
      end
      if (redirect_en && !in_boot) begin
`ifdef PC_FETCH_MISALIGN_CHECK_EN
        misaligned = (redirect_addr[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        if (misaligned) mis_exp = 1'b1;
        else pend_pc = {redirect_addr[63:2], 2'b00};
      end
      in_boot = 1'b0;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_upd();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    at_neg();
    to_pos();
  endtask

  // Returns at a negedge where the chosen output is high, or records a timeout.
  task automatic wait_neg(input bit want_inst, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      at_neg();
      hit = want_inst ? (inst_valid === 1'b1) : (imem_req_valid === 1'b1);
      if (!hit) to_pos();
    end
    if (!hit) begin
      n_chk++;
      $display("FAIL %s: timeout waiting, got 0 expected 1", nm);
      at_neg();
    end
  endtask

  // Memory model: accepts one request at a time and answers after a random latency.
  initial begin
    bit          out_v = 1'b0;
    logic [63:0] out_a = 64'd0;
    int          out_d = 0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        out_v = 1'b0;
      end else if (imem_req_valid === 1'b1) begin
        chk("req_align", {62'd0, imem_req_addr[1:0]}, 64'd0);
        if (imem_req_ready) begin
          chk("one_outstanding", {63'd0, out_v}, 64'd0);
          out_v = 1'b1;
          out_a = imem_req_addr;
          out_d = (lat_max == 0) ? 0 : $urandom_range(0, lat_max);
        end
      end
      @(posedge clk);
      #2;
      imem_rsp_valid = 1'b0;
      if (spurious) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = $urandom;
      end else if (out_v) begin
        if (out_d == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(out_a);
          out_v = 1'b0;
        end else begin
          out_d--;
        end
      end
      imem_req_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end

  // Monitor: every completed instruction handshake is checked against the scoreboard.
  initial begin
    logic [63:0] a_pc;
    logic [31:0] a_w;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
        a_pc = inst_pc;
        a_w  = inst;
        #2;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected: got inst %h pc %h expected none", a_w, a_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_inst_pc", a_pc, e.pc4);
          chk("sb_inst", {32'd0, a_w}, {32'd0, e.word});
        end
      end
    end
  end

  task automatic boot_checks(input string nm);
    chk({nm, "_req_valid"}, {63'd0, imem_req_valid}, 64'd0);
    chk({nm, "_req_addr"}, imem_req_addr, 64'd0);
    chk({nm, "_inst_valid"}, {63'd0, inst_valid}, 64'd0);
    chk({nm, "_inst"}, {32'd0, inst}, 64'd0);
    chk({nm, "_inst_pc"}, inst_pc, 64'd0);
  endtask

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    logic [63:0] tgt;
    rst = 1'b1; inst_ready = 1'b0; redirect_en = 1'b0; redirect_addr = 64'd0;
    cycle(); cycle();
    rst = 1'b0; inst_ready = 1'b1;

    // Reset state and first fetches with minimum latency
    at_neg(); boot_checks("boot"); to_pos();
    at_neg();
    chk("first_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    to_pos();
    at_neg();
    chk("wait_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("wait_inst_valid", {63'd0, inst_valid}, 64'd0);
    to_pos();
    at_neg();
    chk("lat_inst_valid", {63'd0, inst_valid}, 64'd1);
    chk("first_inst_pc", inst_pc, 64'h8000_0004);
    chk("first_inst", {32'd0, inst}, {32'd0, mem_word(RESET_PC)});
    to_pos();
    wait_neg(1'b0, "req4"); chk("req_addr_4", imem_req_addr, 64'h8000_0004); to_pos();
    wait_neg(1'b0, "req8"); chk("req_addr_8", imem_req_addr, 64'h8000_0008); to_pos();
    wait_neg(1'b0, "reqc"); chk("req_addr_c", imem_req_addr, 64'h8000_000C); to_pos();
    wait_neg(1'b0, "req10"); chk("req_addr_10", imem_req_addr, 64'h8000_0010); to_pos();

    // Redirect in HOLD together with the consuming handshake
    cycle();
    redirect_en = 1'b1; redirect_addr = 64'h8000_0100;
    at_neg();
    chk("hold10_valid", {63'd0, inst_valid}, 64'd1);
    chk("hold10_pc", inst_pc, 64'h8000_0014);
    to_pos();
    redirect_en = 1'b0;
    at_neg(); chk("redir_hold_addr", imem_req_addr, 64'h8000_0100); to_pos();

    // Redirect in WAIT coinciding with the response
    redirect_en = 1'b1; redirect_addr = 64'h200;
    at_neg(); chk("wait_redir_req_valid", {63'd0, imem_req_valid}, 64'd0); to_pos();
    redirect_en = 1'b0;
    at_neg();
    chk("wait_redir_no_inst", {63'd0, inst_valid}, 64'd0);
    chk("wait_redir_req_valid2", {63'd0, imem_req_valid}, 64'd1);
    chk("wait_redir_addr", imem_req_addr, 64'h200);
    to_pos();
    rdy_mode = 0;

    // Memory stalls the request; redirect in the third stalled cycle
    wait_neg(1'b1, "hold200"); chk("hold200_pc", inst_pc, 64'h204); to_pos();
    for (int i = 0; i < 5; i++) begin
      redirect_en = (i == 2); redirect_addr = 64'h300;
      at_neg();
      chk("stall_req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("stall_req_addr", imem_req_addr, (i <= 2) ? 64'h204 : 64'h300);
      to_pos();
    end
    redirect_en = 1'b0; rdy_mode = 1;

    // Misaligned redirect
    wait_neg(1'b0, "req300"); to_pos();
    redirect_en = 1'b1; redirect_addr = 64'h8000_0102;
    cycle();
    redirect_en = 1'b0;
    at_neg();
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    chk("misalign_pulse", {63'd0, misalign_err}, 64'd1);
`else
    chk("misalign_forced_addr", imem_req_addr, 64'h8000_0100);
`endif
    to_pos();

    // Reset while holding, then a late response and a redirect during BOOT
    inst_ready = 1'b0;
    wait_neg(1'b1, "hold_before_rst"); to_pos();
    rst = 1'b1;
    cycle();
    rst = 1'b0; spurious = 1'b1; redirect_en = 1'b1; redirect_addr = 64'h400;
    at_neg(); boot_checks("rst_hold"); to_pos();
    spurious = 1'b0; redirect_en = 1'b0; inst_ready = 1'b1;
    at_neg();
    chk("rst_refetch_addr", imem_req_addr, RESET_PC);
    chk("rst_no_inst", {63'd0, inst_valid}, 64'd0);
    to_pos();
    wait_neg(1'b1, "rst_refetch"); chk("rst_refetch_pc", inst_pc, 64'h8000_0004); to_pos();

    // 64-bit wrap of the fetch address
    wait_neg(1'b0, "req_before_wrap"); to_pos();
    redirect_en = 1'b1; redirect_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    redirect_en = 1'b0;
    wait_neg(1'b0, "req_top"); chk("wrap_top_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC); to_pos();
    wait_neg(1'b1, "hold_top"); chk("wrap_inst_pc", inst_pc, 64'd0); to_pos();
    wait_neg(1'b0, "req_zero"); chk("wrap_next_addr", imem_req_addr, 64'd0); to_pos();

    // Randomized traffic
    rdy_mode = 2; lat_max = 3;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      inst_ready = 1'($urandom_range(0, 1));
      redirect_en = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: tgt = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
        1: tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3)) * 64'd4;
        2: tgt = {32'($urandom), 32'($urandom)};
        default: tgt = 64'h8000_0102;
      endcase
      redirect_addr = tgt;
      cycle();
    end

    // Drain
    rst = 1'b0; redirect_en = 1'b0; inst_ready = 1'b1; rdy_mode = 1;
    repeat (20) cycle();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
